// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that packs a byte stream into 32-bit words and writes them to
// instruction memory from address 0. Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   word_count,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   input  logic [ADDR_W-1:0] pc_addr,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              wr_en,
   output logic [DATA_W-1:0] wr_data,
   output logic              cpu_stall,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0] LAST_IDX  = '1;

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FINISH, S_CHECK, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FINISH, S_DONE} state_t;
`endif

   state_t              r_state;
   state_t              w_nextState;
   logic [ADDR_W:0]     r_count;
   logic [ADDR_W-1:0]   r_wordIdx;
   logic [1:0]          r_byteCnt;
   logic [DATA_W-9:0]   r_shift;
   logic                r_wrEn;
   logic [DATA_W-1:0]   r_wrData;
   logic                r_byteReady;

   logic                w_accept;
   logic                w_startOk;
   logic [ADDR_W:0]     w_countClamped;
   logic                w_lastByte;
   logic                w_lastWord;

   assign w_accept       = byte_valid & r_byteReady;
   assign w_startOk      = start & ((r_state == S_IDLE) | (r_state == S_DONE));
   assign w_countClamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
   assign w_lastByte     = (r_byteCnt == 2'd3);
   assign w_lastWord     = ({1'b0, r_wordIdx} == (r_count - (ADDR_W+1)'(1)));

   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_nextState = (w_countClamped == '0) ? S_FINISH : S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_accept && w_lastByte && w_lastWord) begin
               w_nextState = S_FINISH;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_FINISH: w_nextState = S_CHECK;
         S_CHECK: begin
            if (w_accept) begin
               w_nextState = S_DONE;
            end
         end
`else
         S_FINISH: w_nextState = S_DONE;
`endif
         default: w_nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Ready is registered from the next state so it lines up with the state it belongs to.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_byteReady <= 1'b0;
      end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_byteReady <= (w_nextState == S_LOAD) || (w_nextState == S_CHECK);
`else
         r_byteReady <= (w_nextState == S_LOAD);
`endif
      end
   end

   // Bytes shift in big-endian; the 4th byte completes the word and launches a one-cycle write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count   <= '0;
         r_wordIdx <= '0;
         r_byteCnt <= '0;
         r_shift   <= '0;
         r_wrEn    <= 1'b0;
         r_wrData  <= '0;
      end else begin
         r_wrEn <= 1'b0;
         if (w_startOk) begin
            r_count   <= w_countClamped;
            r_wordIdx <= '0;
            r_byteCnt <= '0;
            r_shift   <= '0;
         end else begin
            if (r_wrEn && (r_wordIdx != LAST_IDX)) begin
               r_wordIdx <= r_wordIdx + ADDR_W'(1);
            end
            if ((r_state == S_LOAD) && w_accept) begin
               if (w_lastByte) begin
                  r_byteCnt <= '0;
                  r_wrEn    <= 1'b1;
                  r_wrData  <= {r_shift, byte_in};
               end else begin
                  r_byteCnt <= r_byteCnt + 2'd1;
                  r_shift   <= {r_shift[DATA_W-17:0], byte_in};
               end
            end
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] r_sum;
   logic       r_err;

   // Running mod-256 sum of data bytes, compared against the single byte accepted in CHECK.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sum <= '0;
         r_err <= 1'b0;
      end else if (w_startOk) begin
         r_sum <= '0;
         r_err <= 1'b0;
      end else begin
         if ((r_state == S_LOAD) && w_accept) begin
            r_sum <= r_sum + byte_in;
         end
         if ((r_state == S_CHECK) && w_accept) begin
            r_err <= (byte_in != r_sum);
         end
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign byte_ready = r_byteReady;
   assign wr_en      = r_wrEn;
   assign wr_data    = r_wrData;
   assign cpu_stall  = (r_state != S_DONE);
   assign done       = (r_state == S_DONE);
   assign imem_addr  = ((r_state != S_DONE) || r_wrEn) ? r_wordIdx : pc_addr;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and randomized loads of imem_loader, checked against a word-level
// reference model of the expected memory image.
module tb_imem_loader;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W:0]   word_count = '0;
   logic [7:0]        byte_in = '0;
   logic              byte_valid = 1'b0;
   logic              byte_ready;
   logic [ADDR_W-1:0] pc_addr = '0;
   logic [ADDR_W-1:0] imem_addr;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              cpu_stall;
   logic              done;
   logic              err;

   imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .pc_addr(pc_addr), .imem_addr(imem_addr), .wr_en(wr_en), .wr_data(wr_data),
      .cpu_stall(cpu_stall), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Memory as seen through the write port, plus a log of every write in order.
   logic [DATA_W-1:0] capMem [DEPTH];
   logic [ADDR_W-1:0] logAddr [$];
   logic [DATA_W-1:0] logData [$];

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         capMem[imem_addr] = wr_data;
         logAddr.push_back(imem_addr);
         logData.push_back(wr_data);
      end
   end

   logic [DATA_W-1:0] refMem [DEPTH];
   bit                refValid [DEPTH];
   logic [7:0]        stimBytes [$];
   int                lastBase;
   int                rwc;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        runSum;
   int                cksOverride = -1;
`endif

   typedef struct {
      string       name;
      int          wc;
      int          gapMode;
      logic [63:0] bytes;
      int          expWrites;
      logic [31:0] expWord0;
      logic [31:0] expWord1;
   } vec_t;

   vec_t vecs [5];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got=0x%0h want=0x%0h", name, actual, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic loadBytes64(input logic [63:0] v, input int n);
      stimBytes.delete();
      for (int k = 0; k < n; k++) begin
         stimBytes.push_back(v[63-8*k -: 8]);
      end
   endtask

   // Offers one byte after 'gap' idle cycles and waits (bounded) for it to be taken.
   task automatic pushByte(input logic [7:0] b, input int gap);
      int waitCyc;
      byte_valid = 1'b0;
      repeat (gap) stepCycle();
      byte_in = b;
      byte_valid = 1'b1;
      waitCyc = 0;
      while (byte_ready !== 1'b1 && waitCyc < 16) begin
         stepCycle();
         waitCyc++;
      end
      if (byte_ready !== 1'b1) begin
         checkOutput("byte_ready_timeout", 32'(byte_ready), 32'd1);
      end
      stepCycle();
      byte_valid = 1'b0;
   endtask

   // Called in the cycle after the last data byte (or after start for an empty load).
   task automatic finishCheck(input string name, input bit expectWr);
`ifdef IMEM_LOADER_CHECKSUM_EN
      logic [7:0] cks;
`endif
      checkOutput({name, " finish_wr_en"}, 32'(wr_en), 32'(expectWr));
      checkOutput({name, " finish_done"}, 32'(done), 32'd0);
      checkOutput({name, " finish_ready"}, 32'(byte_ready), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      cks = (cksOverride >= 0) ? 8'(cksOverride) : runSum;
      pushByte(cks, 0);
      checkOutput({name, " err"}, 32'(err), 32'(cks != runSum));
`else
      stepCycle();
      checkOutput({name, " err"}, 32'(err), 32'd0);
`endif
      checkOutput({name, " done"}, 32'(done), 32'd1);
      checkOutput({name, " stall_released"}, 32'(cpu_stall), 32'd0);
      checkOutput({name, " ready_in_done"}, 32'(byte_ready), 32'd0);
   endtask

   // One complete load from stimBytes; expected writes come from the word-level model.
   task automatic applyStimulus(input string name, input int wc, input int gapMode);
      int          eff;
      int          nb;
      int          gap;
      bit          stallHeld;
      logic [31:0] expWord;
      logic [ADDR_W-1:0] pcVal;
      eff = (wc > DEPTH) ? DEPTH : wc;
      nb = 4 * eff;
      lastBase = logAddr.size();
`ifdef IMEM_LOADER_CHECKSUM_EN
      runSum = 8'd0;
`endif
      start = 1'b1;
      word_count = (ADDR_W+1)'(wc);
      stepCycle();
      start = 1'b0;
      checkOutput({name, " stall_after_start"}, 32'(cpu_stall), 32'd1);
      checkOutput({name, " done_after_start"}, 32'(done), 32'd0);
      stallHeld = 1'b1;
      for (int i = 0; i < nb; i++) begin
         if (gapMode == 1) gap = (i > 0) ? 1 : 0;
         else if (gapMode == 2) gap = $urandom_range(0, 2);
         else gap = 0;
         pushByte(stimBytes[i], gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
         runSum = runSum + stimBytes[i];
`endif
         if (cpu_stall !== 1'b1) stallHeld = 1'b0;
      end
      checkOutput({name, " stall_held"}, 32'(stallHeld), 32'd1);
      finishCheck(name, eff > 0);
      checkOutput({name, " write_count"}, 32'(logAddr.size() - lastBase), 32'(eff));
      for (int j = 0; j < eff && (lastBase + j) < logAddr.size(); j++) begin
         expWord = (32'(stimBytes[4*j]) << 24) | (32'(stimBytes[4*j+1]) << 16)
                 | (32'(stimBytes[4*j+2]) << 8) | 32'(stimBytes[4*j+3]);
         checkOutput($sformatf("%s wr_addr[%0d]", name, j), 32'(logAddr[lastBase+j]), 32'(j));
         checkOutput($sformatf("%s wr_data[%0d]", name, j), logData[lastBase+j], expWord);
         refMem[j] = expWord;
         refValid[j] = 1'b1;
      end
      pcVal = ADDR_W'($urandom);
      pc_addr = pcVal;
      #1;
      checkOutput({name, " imem_follows_pc"}, 32'(imem_addr), 32'(pcVal));
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired before end of test");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vecs[0] = '{"basic",        2, 0, 64'h00008020_20100078, 2, 32'h00008020, 32'h20100078};
      vecs[1] = '{"backpressure", 2, 1, 64'h00008020_20100078, 2, 32'h00008020, 32'h20100078};
      vecs[2] = '{"zero_words",   0, 0, 64'h0,                 0, 32'h0,        32'h0};
      vecs[3] = '{"single",       1, 2, 64'hDEADBEEF_00000000, 1, 32'hDEADBEEF, 32'h0};
      vecs[4] = '{"reload",       2, 0, 64'h11223344_55667788, 2, 32'h11223344, 32'h55667788};

      // Reset values, with pc_addr nonzero so the address mux choice is visible.
      pc_addr = 8'h5A;
      rst_n = 1'b0;
      repeat (3) stepCycle();
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset cpu_stall", 32'(cpu_stall), 32'd1);
      checkOutput("reset wr_en", 32'(wr_en), 32'd0);
      checkOutput("reset byte_ready", 32'(byte_ready), 32'd0);
      checkOutput("reset wr_data", wr_data, 32'd0);
      checkOutput("reset err", 32'(err), 32'd0);
      checkOutput("reset imem_addr", 32'(imem_addr), 32'd0);
      rst_n = 1'b1;
      stepCycle();

      for (int i = 0; i < 5; i++) begin
         loadBytes64(vecs[i].bytes, 8);
         applyStimulus(vecs[i].name, vecs[i].wc, vecs[i].gapMode);
         if (vecs[i].expWrites > 0 && logAddr.size() > lastBase)
            checkOutput({vecs[i].name, " word0"}, logData[lastBase], vecs[i].expWord0);
         if (vecs[i].expWrites > 1 && logAddr.size() > lastBase + 1)
            checkOutput({vecs[i].name, " word1"}, logData[lastBase+1], vecs[i].expWord1);
      end

      // start pulses during LOAD must not restart the load.
      loadBytes64(64'hA1B2C3D4_00000000, 4);
      lastBase = logAddr.size();
`ifdef IMEM_LOADER_CHECKSUM_EN
      runSum = 8'hA1 + 8'hB2 + 8'hC3 + 8'hD4;
`endif
      start = 1'b1;
      word_count = 9'd1;
      stepCycle();
      start = 1'b0;
      pushByte(8'hA1, 0);
      pushByte(8'hB2, 0);
      start = 1'b1;
      word_count = 9'd3;
      pushByte(8'hC3, 0);
      start = 1'b0;
      pushByte(8'hD4, 0);
      finishCheck("start_ignored", 1'b1);
      checkOutput("start_ignored write_count", 32'(logAddr.size() - lastBase), 32'd1);
      if (logAddr.size() > lastBase) begin
         checkOutput("start_ignored addr", 32'(logAddr[lastBase]), 32'd0);
         checkOutput("start_ignored data", logData[lastBase], 32'hA1B2C3D4);
      end
      refMem[0] = 32'hA1B2C3D4;

      // Reset after 6 of 8 bytes: word 0 stays written, the partial word is dropped.
      loadBytes64(64'h00008020_20100078, 8);
      lastBase = logAddr.size();
      pc_addr = 8'hC3;
      start = 1'b1;
      word_count = 9'd2;
      stepCycle();
      start = 1'b0;
      for (int i = 0; i < 6; i++) pushByte(stimBytes[i], 0);
      rst_n = 1'b0;
      stepCycle();
      checkOutput("midreset done", 32'(done), 32'd0);
      checkOutput("midreset cpu_stall", 32'(cpu_stall), 32'd1);
      checkOutput("midreset wr_en", 32'(wr_en), 32'd0);
      checkOutput("midreset byte_ready", 32'(byte_ready), 32'd0);
      checkOutput("midreset wr_data", wr_data, 32'd0);
      checkOutput("midreset err", 32'(err), 32'd0);
      checkOutput("midreset imem_addr", 32'(imem_addr), 32'd0);
      checkOutput("midreset write_count", 32'(logAddr.size() - lastBase), 32'd1);
      if (logAddr.size() > lastBase) begin
         checkOutput("midreset word0", logData[lastBase], 32'h00008020);
      end
      refMem[0] = 32'h00008020;
      rst_n = 1'b1;
      byte_valid = 1'b1;
      byte_in = 8'hEE;
      stepCycle();
      stepCycle();
      checkOutput("idle ready_low", 32'(byte_ready), 32'd0);
      byte_valid = 1'b0;
      applyStimulus("fresh_after_reset", 2, 0);
      if (logAddr.size() > lastBase + 1) begin
         checkOutput("fresh word1", logData[lastBase+1], 32'h20100078);
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      loadBytes64(64'h01020304_00000000, 4);
      cksOverride = 8'h0A;
      applyStimulus("cks_good", 1, 0);
      checkOutput("cks_good err_hand", 32'(err), 32'd0);
      cksOverride = 8'h0B;
      applyStimulus("cks_bad", 1, 0);
      checkOutput("cks_bad err_hand", 32'(err), 32'd1);
      checkOutput("cks_bad done_hand", 32'(done), 32'd1);
      cksOverride = -1;
`endif

      for (int r = 0; r < 6; r++) begin
         rwc = $urandom_range(1, 6);
         stimBytes.delete();
         for (int k = 0; k < 4 * rwc; k++) stimBytes.push_back(8'($urandom));
         applyStimulus($sformatf("random%0d", r), rwc, 2);
      end

      // Oversized word_count clamps to the full memory depth without wrapping.
      rwc = $urandom_range(DEPTH + 1, 2 * DEPTH - 1);
      stimBytes.delete();
      for (int k = 0; k < 4 * DEPTH; k++) stimBytes.push_back(8'($urandom));
      applyStimulus("clamp", rwc, 0);

      for (int a = 0; a < DEPTH; a++) begin
         if (refValid[a]) checkOutput($sformatf("mem[%0d]", a), capMem[a], refMem[a]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
